led_result_reader: RTL and testbench
====================================

# led_result_reader

Output-side companion to the switch/LED Twofish front end: accepts one 128-bit result block (ciphertext or plaintext) over a ready/valid handshake and presents it on the board's 8 LEDs one byte at a time, advanced by a push-button step input. It is the reader end of the switch-loading path: the loader writes a block in 16-bit switch words, and this block reads the result out in 8-bit LED bytes, with a 5-bit state display showing the byte index.

## Interface
Parameters:
- NBYTES, 16, number of bytes per block; block width is 8*NBYTES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- data_in  in  8*NBYTES  result block from the cipher core.
- data_valid  in  1  data_in is valid this cycle.
- data_ready  out  1  block can accept a new result (IDLE only).
- mode_in  in  1  cipher mode tag for the block (1 = decrypt), captured with data.
- step  in  1  raw push-button level, asynchronous to clk.
- LED  out  8  currently displayed byte.
- state_led  out  5  current byte index (0..NBYTES-1).
- mode_led  out  1  captured mode tag.
- busy_led  out  1  high while a block is being displayed.
- done  out  1  one-cycle pulse after the last byte is stepped past.
- parity_led  out  1  present only with LED_READER_PARITY_EN.

## Operation
- The FSM has two states. Reset state is IDLE.
- In IDLE: data_ready=1, busy_led=0, LED=0, state_led=0.
  - When data_valid=1, data_in is captured into a holding register, mode_in into mode_led, idx is set to 0, and the FSM moves to SHOW.
  - Step edges are ignored in IDLE.
- In SHOW: data_ready=0, busy_led=1.
  - LED shows byte idx, MSB-first: idx 0 shows data[8*NBYTES-1 -: 8], and idx NBYTES-1 shows data[7:0].
  - state_led = idx, zero-extended to 5 bits.
  - data_valid is ignored; the held block does not change.
- Step handling:
  - step passes through a 2-flop synchronizer (s1, s2) and a history flop (s3).
  - A step edge is s2 & ~s3, one cycle wide per button press regardless of how long the button is held.
- On a step edge in SHOW:
  - if idx < NBYTES-1, idx increments;
  - if idx == NBYTES-1, done pulses for 1 cycle, the holding register clears, and the FSM returns to IDLE. mode_led holds its value until the next capture.
- idx never wraps. The only exit from SHOW at the last byte is the done transition.
- Reset asserted mid-display aborts immediately: FSM goes to IDLE, holding register, idx and sync flops clear, and no done pulse is produced.
- No debouncing is done here; the board-level debouncer upstream provides clean levels.

## Timing
- Reset values: LED=0, state_led=0, mode_led=0, busy_led=0, done=0, data_ready=1, parity_led=0; s1/s2/s3 = 0.
- Capture: with data_valid high at edge k in IDLE, LED shows byte 0 and busy_led=1 from edge k. data_ready drops from the same edge.
- Step latency: step first sampled high at edge k gives s2=1 after k+1 and the edge is detected during cycle k+1..k+2. idx and LED update at edge k+2. done asserts at edge k+2 when leaving the last byte and deasserts at k+3.
- Back-to-back: data_ready returns high at the done edge, so a new block can be captured at the edge after done.
- A step held high through reset release yields one edge after release. In IDLE this edge is discarded.

## Configuration
- Macro LED_READER_PARITY_EN.
- Defined: output parity_led = XOR reduction of the displayed byte in SHOW, and 0 in IDLE. It is registered alongside LED.
- Undefined: the parity_led port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset/idle: reset=0 then 1 with data_valid=0 -> LED=0, state_led=0, data_ready=1, busy_led=0, done never pulses; step presses have no effect.
- Capture and first byte: data_in=128'h00112233_44556677_8899AABB_CCDDEEFF, mode_in=1, data_valid for 1 cycle -> LED=8'h00, state_led=0, mode_led=1, data_ready=0.
- Full readout: 16 clean step presses -> LED sequence 00,11,...,FF with state_led 0..15. The 16th press produces a single-cycle done and a return to IDLE. Each update lands 2 edges after the first high sample.
- Long press and ignored valid: hold step high for 20 cycles and assert data_valid with new data during SHOW -> idx advances by exactly 1 and LED still shows the original block.
- Reset mid-display: reset at idx=7 -> immediate LED=0, state_led=0, no done. A new capture then starts at byte 0.
- Parity (macro defined): block byte 0 = 8'h07 -> parity_led=1; after a step to byte 8'h03 -> parity_led=0; parity_led=0 in IDLE.

Source files
------------

// File: rtl/led_result_reader_if.sv
// rtl/led_result_reader_if.sv - result-block handshake between cipher core and LED reader
interface led_result_reader_if #(
  parameter int NBYTES = 16
);
  logic [8*NBYTES-1:0] data_in;
  logic                data_valid;
  logic                data_ready;
  logic                mode_in;

  modport master (
    output data_in,
    output data_valid,
    output mode_in,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  mode_in,
    output data_ready
  );
endinterface

// File: rtl/led_result_reader.sv
// rtl/led_result_reader.sv - shows a captured result block on 8 LEDs, one byte per step press
// Optional LED_READER_PARITY_EN adds a registered parity_led output for the displayed byte.
module led_result_reader #(
  parameter int NBYTES = 16
) (
  input  logic                clk,
  input  logic                reset,
  led_result_reader_if.slave  bus,
  input  logic                step,
  output logic [7:0]          LED,
  output logic [4:0]          state_led,
  output logic                mode_led,
  output logic                busy_led,
  output logic                done
`ifdef LED_READER_PARITY_EN
  ,output logic               parity_led
`endif
);

  localparam int         W    = 8 * NBYTES;
  localparam logic [4:0] LAST = 5'(NBYTES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t         state, state_n;
  logic [W-1:0]   hold, hold_n, shifted;
  logic [4:0]     idx, idx_n;
  logic           mode_n, done_n;
  logic [7:0]     led_n;
  logic           s1, s2, s3;
  logic           step_edge;

  // Button level crosses into clk here; s3 keeps one cycle of history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= step;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step_edge = s2 & ~s3;

  always_comb begin
    state_n = state;
    hold_n  = hold;
    idx_n   = idx;
    mode_n  = mode_led;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.data_valid) begin
          hold_n  = bus.data_in;
          mode_n  = bus.mode_in;
          idx_n   = 5'd0;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (step_edge) begin
          if (idx == LAST) begin
            done_n  = 1'b1;
            hold_n  = '0;
            idx_n   = 5'd0;
            state_n = IDLE;
          end else begin
            idx_n = idx + 5'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Byte 0 is the most significant byte, so shift the wanted byte up to the top.
  always_comb begin
    shifted = hold_n << {idx_n, 3'b000};
    led_n   = (state_n == SHOW) ? shifted[W-1 -: 8] : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold     <= '0;
      idx      <= 5'd0;
      mode_led <= 1'b0;
      done     <= 1'b0;
      LED      <= 8'h00;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      idx      <= idx_n;
      mode_led <= mode_n;
      done     <= done_n;
      LED      <= led_n;
    end
  end

`ifdef LED_READER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_led <= 1'b0;
    else        parity_led <= ^led_n;
  end
`endif

  assign bus.data_ready = (state == IDLE);
  assign busy_led       = (state == SHOW);
  assign state_led      = idx;

endmodule

// File: tb/tb_led_result_reader.sv
// tb/tb_led_result_reader.sv - scoreboard bench for led_result_reader against a byte-array model
module tb_led_result_reader;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [7:0] LED;
  logic [4:0] state_led;
  logic       mode_led, busy_led, done;
`ifdef LED_READER_PARITY_EN
  logic       parity_led;
`endif

  led_result_reader_if #(.NBYTES(N)) bus_if ();

  led_result_reader #(.NBYTES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .step      (step),
    .LED       (LED),
    .state_led (state_led),
    .mode_led  (mode_led),
    .busy_led  (busy_led),
    .done      (done)
`ifdef LED_READER_PARITY_EN
    ,.parity_led (parity_led)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] led;
    logic [4:0] idx;
    logic       busy;
    logic       dn;
    logic       mode;
    int         at;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 0;

  // Reference model: block as a byte array indexed MSB-first, plus display position.
  logic [7:0] m_bytes [N];
  int         m_idx = 0;
  bit         m_showing = 0;
  logic       m_mode = 1'b0;

  function automatic ev_t mk(logic [7:0] l, int i, logic b, logic d, logic m, int at);
    ev_t e;
    e.led = l; e.idx = 5'(i); e.busy = b; e.dn = d; e.mode = m; e.at = at;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every visible change of the display pops one expected event.
  initial begin
    logic [15:0] prev, cur, exp;
    ev_t e;
    wait (mon_en);
    prev = {LED, state_led, busy_led, done, mode_led};
    forever begin
      @(posedge clk); #1;
      cur = {LED, state_led, busy_led, done, mode_led};
      if (cur !== prev) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change actual=%0h expected=no change at cycle %0d", cur, cyc);
        end else begin
          e = sbq.pop_front();
          exp = {e.led, e.idx, e.busy, e.dn, e.mode};
          if (cur !== exp) begin
            errors++;
            $display("FAIL display actual=%0h expected=%0h at cycle %0d", cur, exp, cyc);
          end
          chk("latency", 32'(cyc), 32'(e.at));
        end
        prev = cur;
      end
`ifdef LED_READER_PARITY_EN
      chk("parity", {31'd0, parity_led}, {31'd0, busy_led ? ^LED : 1'b0});
`endif
    end
  end

  task automatic capture(logic [8*N-1:0] b, logic m);
    bus_if.data_in    = b;
    bus_if.mode_in    = m;
    bus_if.data_valid = 1'b1;
    if (!m_showing) begin
      for (int i = 0; i < N; i++) m_bytes[i] = b[8*(N-1-i) +: 8];
      m_idx = 0; m_mode = m; m_showing = 1;
      sbq.push_back(mk(m_bytes[0], 0, 1'b1, 1'b0, m, cyc + 1));
    end
    @(negedge clk);
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = {$urandom, $urandom, $urandom, $urandom};
    bus_if.mode_in    = 1'($urandom);
  endtask

  task automatic press(int hold, bit inject_valid);
    int c;
    c = cyc;
    step = 1'b1;
    if (m_showing) begin
      if (m_idx < N - 1) begin
        m_idx++;
        sbq.push_back(mk(m_bytes[m_idx], m_idx, 1'b1, 1'b0, m_mode, c + 3));
      end else begin
        sbq.push_back(mk(8'h00, 0, 1'b0, 1'b1, m_mode, c + 3));
        sbq.push_back(mk(8'h00, 0, 1'b0, 1'b0, m_mode, c + 4));
        m_showing = 0; m_idx = 0;
      end
    end
    for (int k = 0; k < hold; k++) begin
      if (inject_valid && k == 5) capture({$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      else @(negedge clk);
    end
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic readout_rest();
    while (m_showing) press($urandom_range(1, 4), 0);
    chk("ready_after_done", {31'd0, bus_if.data_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; step = 1'b0;
    bus_if.data_valid = 1'b0; bus_if.data_in = '0; bus_if.mode_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", {24'd0, LED}, 32'd0);
    chk("rst_state_led", {27'd0, state_led}, 32'd0);
    chk("rst_ready", {31'd0, bus_if.data_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy_led}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mode", {31'd0, mode_led}, 32'd0);
    mon_en = 1;
    // Step held through reset release, then idle presses: none may change the display.
    step = 1'b1;
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    press(1, 0); press(3, 0);
    chk("idle_ready", {31'd0, bus_if.data_ready}, 32'd1);

    capture(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    chk("capture_ready_low", {31'd0, bus_if.data_ready}, 32'd0);
    for (int i = 0; i < N; i++) press(1, 0);
    chk("ready_after_done", {31'd0, bus_if.data_ready}, 32'd1);

    for (int r = 0; r < 3; r++) begin
      capture({$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      readout_rest();
    end

    // Long press with a competing data_valid in SHOW.
    capture({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    press(20, 1);
    readout_rest();

    // Abort at byte 7.
    capture({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    for (int i = 0; i < 7; i++) press(2, 0);
    reset = 1'b0;
    sbq.push_back(mk(8'h00, 0, 1'b0, 1'b0, 1'b0, cyc + 1));
    m_showing = 0; m_idx = 0; m_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    capture({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    readout_rest();

    capture(128'h0703A5FF_00010203_04050607_08090A0B, 1'b0);
    readout_rest();

    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
